// File: rtl/element_wise_arbiter_pkg.sv
// Shared definitions for the element-wise arbiter: unit op codes, arbiter states
// and the canned divide-by-zero result.
package element_wise_arbiter_pkg;

  typedef enum logic [2:0] {
    EW_OP_ADD = 3'd0,
    EW_OP_SUB = 3'd1,
    EW_OP_MUL = 3'd2,
    EW_OP_DIV = 3'd3,
    EW_OP_AND = 3'd4,
    EW_OP_OR  = 3'd5,
    EW_OP_XOR = 3'd6,
    EW_OP_NOT = 3'd7
  } ew_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  localparam logic [15:0] EW_DIV0_RESULT = 16'hFFFF;

endpackage

// File: rtl/element_wise_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the search starts one past ptr so
// the most recently served requester always has the lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_req && req[idx]) begin
        any_req        = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/element_wise_arbiter.sv
// element_wise_arbiter: shares one element_wise_op unit among NUM_REQ requesters.
// Optional macro EW_ARB_DIV_GUARD_EN answers divide-by-zero requests locally without issuing them.
module element_wise_arbiter
  import element_wise_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_b,
  input  logic [NUM_REQ*3-1:0]      req_op_type,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         eu_operand_a,
  output logic [DATA_W-1:0]         eu_operand_b,
  output logic [2:0]                eu_op_type,
  output logic                      eu_valid,
  input  logic                      eu_ready,
  input  logic [DATA_W-1:0]         eu_data,
  input  logic                      eu_valid_out,
  output logic                      eu_ready_out,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               accept;
  logic               capture;
  logic               div0_bypass;
  logic [DATA_W-1:0]  win_a;
  logic [DATA_W-1:0]  win_b;
  logic [2:0]         win_op;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  assign win_a  = req_operand_a[int'(win_idx)*DATA_W +: DATA_W];
  assign win_b  = req_operand_b[int'(win_idx)*DATA_W +: DATA_W];
  assign win_op = req_op_type[int'(win_idx)*3 +: 3];

`ifdef EW_ARB_DIV_GUARD_EN
  assign div0_bypass = (win_op == 3'(EW_OP_DIV)) && (win_b == '0);
`else
  assign div0_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // eu_ready_out only mirrors eu_valid_out: the unit discards a result if ready is already high on entry.
  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    eu_valid     = 1'b0;
    eu_ready_out = 1'b0;
    rsp_valid    = '0;
    accept       = 1'b0;
    capture      = 1'b0;
    case (state)
      ARB_IDLE: begin
        req_ready = win_grant;
        if (any_req) begin
          accept    = 1'b1;
          state_nxt = div0_bypass ? ARB_RESP : ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        eu_valid = 1'b1;
        if (eu_ready) state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        eu_ready_out = eu_valid_out;
        if (eu_valid_out) begin
          capture   = 1'b1;
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign busy = (state != ARB_IDLE);

  // Operands are frozen at accept and only replaced by the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= IDX_W'(NUM_REQ - 1);
      owner        <= '0;
      eu_operand_a <= '0;
      eu_operand_b <= '0;
      eu_op_type   <= '0;
      rsp_data     <= '0;
    end else begin
      if (accept) begin
        ptr          <= win_idx;
        owner        <= win_idx;
        eu_operand_a <= win_a;
        eu_operand_b <= win_b;
        eu_op_type   <= win_op;
      end
      if (capture)                    rsp_data <= eu_data;
      else if (accept && div0_bypass) rsp_data <= DATA_W'(EW_DIV0_RESULT);
    end
  end

`ifdef EW_ARB_DIV_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rsp_err <= 1'b0;
    else if (capture)               rsp_err <= 1'b0;
    else if (accept && div0_bypass) rsp_err <= 1'b1;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
